// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: state encoding, byte width and
// a constant-evaluable ceil(log2) used to size pointers and counters.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (int'(32'd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N, returned both one-hot and as an index.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [PW-1:0] idx,
  output logic          valid
);

  int cand;

  always_comb begin
    winner = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!valid && req[cand[PW-1:0]]) begin
        winner[cand[PW-1:0]] = 1'b1;
        idx                  = cand[PW-1:0];
        valid                = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among
// NUM_REQ sources. Optional idle-grant timeout: UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
`ifdef UART_TX_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          ack,
  output logic [NUM_REQ-1:0]          grant,
  output logic [BYTE_W-1:0]           tx_data,
  output logic                        new_tx_data,
  input  logic                        tx_busy
`ifdef UART_TX_ARB_TIMEOUT_EN
  , output logic                      timeout_err
`endif
);

  localparam int PW = clog2(NUM_REQ);

  state_t              state, next_state;
  logic [NUM_REQ-1:0]  pick_winner;
  logic [PW-1:0]       pick_idx;
  logic                pick_valid;
  logic [PW-1:0]       ptr, gidx, next_ptr;
  logic                last_seen;
  logic                sel_req, sel_last, take, release_to;
  logic [BYTE_W-1:0]   sel_byte;

  rr_picker #(.N(NUM_REQ), .PW(PW)) u_picker (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_winner),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Only the granted requester's byte, last flag and request are looked at.
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == PW'(i)) begin
        sel_byte = req_data[i*BYTE_W +: BYTE_W];
      end else begin
        sel_byte = sel_byte;
      end
    end
  end

  assign sel_req  = req[gidx];
  assign sel_last = req_last[gidx];
  assign next_ptr = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] idle_cnt;

  assign release_to = (state == SEND) && !sel_req && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= release_to;
      if ((state == SEND) && !sel_req && !release_to) begin
        idle_cnt <= idle_cnt + CW'(1);
      end else begin
        idle_cnt <= '0;
      end
    end
  end
`else
  assign release_to = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (pick_valid) next_state = SEND;
        else            next_state = IDLE;
      end
      SEND: begin
        if (take)            next_state = GAP;
        else if (release_to) next_state = IDLE;
        else                 next_state = SEND;
      end
      GAP: begin
        if (last_seen) next_state = IDLE;
        else           next_state = SEND;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    take = 1'b0;
    ack  = '0;
    if ((state == SEND) && sel_req && !tx_busy) begin
      take = 1'b1;
      ack  = grant;
    end else begin
      take = 1'b0;
      ack  = '0;
    end
  end

  // Grant, pointer and transmitter-side registers; pointer only moves on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant       <= '0;
      gidx        <= '0;
      ptr         <= '0;
      last_seen   <= 1'b0;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
    end else begin
      new_tx_data <= take;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant <= pick_winner;
            gidx  <= pick_idx;
          end else begin
            grant <= '0;
          end
        end
        SEND: begin
          if (take) begin
            tx_data   <= sel_byte;
            last_seen <= sel_last;
          end else if (release_to) begin
            grant <= '0;
            ptr   <= next_ptr;
          end else begin
            last_seen <= last_seen;
          end
        end
        GAP: begin
          if (last_seen) begin
            grant <= '0;
            ptr   <= next_ptr;
          end else begin
            grant <= grant;
          end
        end
        default: grant <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued message sources, a strobe log and
// hand-computed expected byte/owner sequences.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        tx_busy;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  uart_tx_arbiter #(
    .NUM_REQ(4)
`ifdef UART_TX_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .req_last    (req_last),
    .ack         (ack),
    .grant       (grant),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .tx_busy     (tx_busy)
`ifdef UART_TX_ARB_TIMEOUT_EN
    , .timeout_err (timeout_err)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [8:0] srcq [4][$];   // {last, byte}
  logic [8:0] popped;
  logic [7:0] log_d [$];
  logic [3:0] log_g [$];
  int         log_c [$];
  int         to_c  [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Sources: present the head of each queue shortly after every rising edge.
  initial begin
    req      = 4'd0;
    req_data = 32'd0;
    req_last = 4'd0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (srcq[i].size() > 0) begin
          req[i]            = 1'b1;
          req_data[i*8 +: 8] = srcq[i][0][7:0];
          req_last[i]       = srcq[i][0][8];
        end else begin
          req[i]      = 1'b0;
          req_last[i] = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (ack[i] && srcq[i].size() > 0) popped = srcq[i].pop_front();
    end
  end

  initial forever begin
    @(negedge clk);
    if (new_tx_data) begin
      log_d.push_back(tx_data);
      log_g.push_back(grant);
      log_c.push_back(cyc);
    end
    if (!rst && ack != 4'd0) chk("ack_owner", 32'(ack & ~grant), 32'd0);
`ifdef UART_TX_ARB_TIMEOUT_EN
    if (timeout_err) to_c.push_back(cyc);
`endif
  end

  task automatic wait_idle(input string tag, input int n);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      #1;
      if (log_d.size() >= n && grant == 4'd0 && srcq[0].size() == 0 && srcq[1].size() == 0 &&
          srcq[2].size() == 0 && srcq[3].size() == 0)
        done = 1'b1;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic exp_log(input string tag, input int idx, input logic [7:0] d, input logic [3:0] g);
    if (idx < log_d.size()) begin
      chk({tag, "_data"}, 32'(log_d[idx]), 32'(d));
      chk({tag, "_owner"}, 32'(log_g[idx]), 32'(g));
    end else begin
      chk({tag, "_missing"}, 32'(log_d.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int b;
    int n_ack;
    int n_str;
    rst     = 1'b1;
    tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_strobe", 32'(new_tx_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;

    // Single requester sends "OK\n"
    b = log_d.size();
    srcq[0].push_back({1'b0, 8'h4F});
    srcq[0].push_back({1'b0, 8'h4B});
    srcq[0].push_back({1'b1, 8'h0A});
    wait_idle("ok_done", b + 3);
    exp_log("ok0", b,     8'h4F, 4'b0001);
    exp_log("ok1", b + 1, 8'h4B, 4'b0001);
    exp_log("ok2", b + 2, 8'h0A, 4'b0001);
    if (log_c.size() >= b + 3) begin
      chk("ok_spacing1", 32'(log_c[b+1] - log_c[b]), 32'd2);
      chk("ok_spacing2", 32'(log_c[b+2] - log_c[b+1]), 32'd2);
    end else begin
      chk("ok_spacing", 32'(log_c.size()), 32'(b + 3));
    end
    chk("ok_count", 32'(log_d.size()), 32'(b + 3));

    // Contention between requesters 1 and 2, two-byte packets each
    b = log_d.size();
    srcq[1].push_back({1'b0, 8'h11});
    srcq[1].push_back({1'b1, 8'h12});
    srcq[2].push_back({1'b0, 8'h21});
    srcq[2].push_back({1'b1, 8'h22});
    wait_idle("cont_done", b + 4);
    exp_log("cont0", b,     8'h11, 4'b0010);
    exp_log("cont1", b + 1, 8'h12, 4'b0010);
    exp_log("cont2", b + 2, 8'h21, 4'b0100);
    exp_log("cont3", b + 3, 8'h22, 4'b0100);

    // Pointer should now sit at 3: requester 3 beats requester 0
    b = log_d.size();
    srcq[0].push_back({1'b1, 8'h03});
    srcq[3].push_back({1'b1, 8'h33});
    wait_idle("ptr_done", b + 2);
    exp_log("ptr0", b,     8'h33, 4'b1000);
    exp_log("ptr1", b + 1, 8'h03, 4'b0001);

    // Fairness: 0 and 3 continuously requesting single-byte packets
    b = log_d.size();
    for (int i = 0; i < 3; i++) begin
      srcq[0].push_back({1'b1, 8'hA0 + 8'(i)});
      srcq[3].push_back({1'b1, 8'hB0 + 8'(i)});
    end
    wait_idle("fair_done", b + 6);
    exp_log("fair0", b,     8'hB0, 4'b1000);
    exp_log("fair1", b + 1, 8'hA0, 4'b0001);
    exp_log("fair2", b + 2, 8'hB1, 4'b1000);
    exp_log("fair3", b + 3, 8'hA1, 4'b0001);
    exp_log("fair4", b + 4, 8'hB2, 4'b1000);
    exp_log("fair5", b + 5, 8'hA2, 4'b0001);

    // Backpressure: 20 busy cycles while granted
    b = log_d.size();
    tx_busy = 1'b1;
    srcq[2].push_back({1'b1, 8'h5A});
    repeat (2) begin
      @(negedge clk);
      #1;
    end
    chk("bp_grant", 32'(grant), 32'b0100);
    n_ack = 0;
    n_str = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (ack != 4'd0) n_ack++;
      if (new_tx_data) n_str++;
    end
    chk("bp_no_ack", 32'(n_ack), 32'd0);
    chk("bp_no_strobe", 32'(n_str), 32'd0);
    @(posedge clk);
    #1;
    tx_busy = 1'b0;
    @(negedge clk);
    #1;
    chk("bp_ack_first_free", 32'(ack), 32'b0100);
    wait_idle("bp_done", b + 1);
    exp_log("bp0", b, 8'h5A, 4'b0100);

    // Reset mid-packet after the first of three bytes
    b = log_d.size();
    srcq[0].push_back({1'b0, 8'h61});
    srcq[0].push_back({1'b0, 8'h62});
    srcq[0].push_back({1'b1, 8'h63});
    for (int k = 0; k < 50 && log_d.size() == b; k++) begin
      @(negedge clk);
      #1;
    end
    chk("mid_strobe_seen", 32'(log_d.size()), 32'(b + 1));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_strobe", 32'(new_tx_data), 32'd0);
    srcq[0].delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_log("mid0", b, 8'h61, 4'b0001);
    chk("mid_count", 32'(log_d.size()), 32'(b + 1));
    srcq[1].push_back({1'b1, 8'h71});
    srcq[3].push_back({1'b1, 8'h73});
    wait_idle("post_rst_done", b + 3);
    exp_log("post0", b + 1, 8'h71, 4'b0010);
    exp_log("post1", b + 2, 8'h73, 4'b1000);

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Owner stalls mid-packet; requester 2 takes over after the timeout
    b = log_d.size();
    srcq[0].push_back({1'b0, 8'h81});
    srcq[2].push_back({1'b1, 8'h82});
    wait_idle("to_done", b + 2);
    exp_log("to0", b,     8'h81, 4'b0001);
    exp_log("to1", b + 1, 8'h82, 4'b0100);
    chk("to_pulses", 32'(to_c.size()), 32'd1);
    if (to_c.size() >= 1 && log_c.size() > b)
      chk("to_delay", 32'(to_c[0] - log_c[b]), 32'd17);
    else
      chk("to_delay_missing", 32'(to_c.size()), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (tx_data / new_tx_data / tx_busy) between NUM_REQ message sources, e.g. several message printers and a debug dumper.
- Grants are per packet and round-robin. The grant is held until the requester flags its last byte, so one packet's bytes never interleave with another's.
- Sits between the message sources and the serial TX block; all logic is synchronous to the single system clock.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, idle cycles before a held grant is forcibly released (only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  per-requester "byte available".
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- req_last  in  NUM_REQ  presented byte is the last of its packet.
- ack  out  NUM_REQ  one-cycle pulse: requester i's byte was taken this cycle.
- grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- tx_data  out  8  byte to the UART transmitter.
- new_tx_data  out  1  one-cycle strobe: tx_data is valid.
- tx_busy  in  1  transmitter busy.

Behaviour:
- Reset values: grant=0, ack=0, tx_data=8'h00, new_tx_data=0, state=IDLE, round-robin pointer=0 (requester 0 has highest priority first).
- Reset mid-packet drops the grant immediately. A byte already strobed is not recalled.
- States: IDLE, SEND, GAP.
- IDLE:
  - If any req is high, choose the first requester at or after the pointer (wrapping modulo NUM_REQ).
  - Register its grant bit next cycle and go to SEND.
  - If no req, stay in IDLE.
- SEND, granted index g:
  - If req[g] && !tx_busy, take the byte in this cycle: ack[g]=1 (combinational), and register tx_data<=req_data[g], new_tx_data<=1 (visible the next cycle).
  - Latch last_seen<=req_last[g], then go to GAP.
  - Otherwise hold the grant and wait; no timeout unless the optional feature is compiled in.
- GAP:
  - new_tx_data is high for exactly this one cycle, then drops. The transmitter raises tx_busy during it, so tx_busy is not sampled in GAP.
  - If last_seen: clear grant, set pointer=(g+1) mod NUM_REQ, go to IDLE.
  - Else return to SEND.
- Latency: req rising in IDLE -> grant 1 cycle later -> ack in the grant cycle if !tx_busy -> new_tx_data the following cycle.
- Maximum throughput is one byte per 2 cycles, gated by tx_busy.
- Simultaneous requests are resolved by the round-robin pointer only. A requester raising req while another holds the grant waits for that packet's last byte.
- req dropping mid-packet without last: grant is held and the arbiter waits in SEND.
- A single-byte packet (req_last high with the first byte) releases the grant after one GAP.
- A req on a non-granted index never produces ack.
- tx_data holds its last value between strobes.
- Only the granted requester's req_data and req_last are sampled.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs while in SEND with req[g] low, and clears on any ack.
  - On reaching TIMEOUT_CYCLES it clears grant, advances the pointer past g and enters IDLE without a strobe.
  - Adds output timeout_err (1 bit), a one-cycle pulse on release; its reset value is 0.
- Undefined: no counter and no timeout_err port; a grant is held indefinitely.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants (IDLE, SEND, GAP);
  - BYTE_W=8;
  - function clog2 for pointer width.
- One natural sub-module: rr_picker. It is combinational and maps req plus pointer to a one-hot winner and its index, and is reused by other arbiters in the design.

Test Plan:
- Single requester: req[0]=1 for "OK\n" (0x4F, 0x4B, 0x0A, last on 0x0A), tx_busy=0 -> three strobes 2 cycles apart with tx_data 0x4F, 0x4B, 0x0A, then grant=0.
- Contention: req[1] and req[2] rise the same cycle after reset, 2-byte packets each -> requester 1's bytes go out first, then requester 2's; no interleaving. Pointer ends at 3.
- Fairness: req[0] and req[3] held continuously with 1-byte packets -> grants alternate 0, 3, 0, 3.
- Backpressure: tx_busy held high 20 cycles while granted -> no ack and no strobe for 20 cycles. The byte is taken on the first cycle tx_busy=0.
- Reset: assert rst mid-packet after 1 of 3 bytes -> grant=0, new_tx_data=0 immediately. After release, requester 0 wins first.
- With UART_TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: owner drops req mid-packet -> timeout_err pulses after 16 cycles and the next waiting requester is granted.
